// File: rtl/cdc_change_queue_if.sv
// Valid/ready stream carrying each detected change from the queue to its consumer.
interface cdc_change_queue_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;

    modport master (output out_data, output out_valid, input out_ready);
    modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/cdc_change_queue_fifo.sv
// Show-ahead FIFO: head entry is visible combinationally from the registered read pointer.
module showahead_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH_BITS = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head_data,
    output logic [DEPTH_BITS:0]   level,
    output logic                  full,
    output logic                  empty
);
    localparam int DEPTH = 1 << DEPTH_BITS;
    localparam logic [DEPTH_BITS:0] FULL_LEVEL = (DEPTH_BITS + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DEPTH_BITS-1:0] wr_ptr_reg;
    logic [DEPTH_BITS-1:0] rd_ptr_reg;
    logic [DEPTH_BITS:0]   level_reg;
    logic                  do_push;
    logic                  do_pop;

    assign empty     = (level_reg == '0);
    assign full      = (level_reg == FULL_LEVEL);
    assign level     = level_reg;
    assign head_data = mem[rd_ptr_reg];

    // A pop on a full queue frees the slot the simultaneous push needs.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   level_reg <= level_reg + 1'b1;
                2'b01:   level_reg <= level_reg - 1'b1;
                default: level_reg <= level_reg;
            endcase
        end
    end
endmodule

// File: rtl/cdc_change_queue.sv
// Detects every change of a synchronized value and queues it for a valid/ready consumer,
// counting changes lost to a full queue.
module cdc_change_queue #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH_BITS = 2,
    parameter int INIT_EVENT = 0,
    parameter int DROP_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] data_in,
    cdc_change_queue_if.master    q,
    output logic [DEPTH_BITS:0]   level,
    output logic [DROP_WIDTH-1:0] drop_count
);
    logic [DATA_WIDTH-1:0] prev_reg;
    logic                  armed_reg;
    logic [DROP_WIDTH-1:0] drop_reg;
    logic                  push_req;
    logic                  pop_req;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  drop_event;

    // Before arming, the first sample is only a baseline unless INIT_EVENT asks for it.
    assign push_req   = armed_reg ? (data_in != prev_reg) : (INIT_EVENT != 0);
    assign pop_req    = q.out_valid & q.out_ready;
    assign drop_event = push_req & fifo_full & ~pop_req;

    assign q.out_valid = ~fifo_empty;
    assign drop_count  = drop_reg;

    showahead_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH_BITS (DEPTH_BITS)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_req),
        .push_data (data_in),
        .pop       (pop_req),
        .head_data (q.out_data),
        .level     (level),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_reg  <= '0;
            armed_reg <= 1'b0;
            drop_reg  <= '0;
        end else begin
            prev_reg  <= data_in;
            armed_reg <= 1'b1;
            if (drop_event && (drop_reg != '1)) begin
                drop_reg <= drop_reg + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_cdc_change_queue.sv
// Bench for cdc_change_queue: three configurations driven in lockstep, checked against
// constant vectors, hand sequences and a queue-based reference model.
module tb_cdc_change_queue;
    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] data_in;
    logic       ready;

    always #5 clk = ~clk;

    cdc_change_queue_if #(.DATA_WIDTH(8)) qif0 ();
    cdc_change_queue_if #(.DATA_WIDTH(8)) qif1 ();
    cdc_change_queue_if #(.DATA_WIDTH(8)) qif2 ();
    assign qif0.out_ready = ready;
    assign qif1.out_ready = ready;
    assign qif2.out_ready = ready;

    logic [2:0] lvl0, lvl1, lvl2;
    logic [7:0] dc0, dc1;
    logic [1:0] dc2;

    cdc_change_queue #(.DATA_WIDTH(8), .DEPTH_BITS(2), .INIT_EVENT(0), .DROP_WIDTH(8)) dut0 (
        .clk(clk), .reset(reset), .data_in(data_in), .q(qif0), .level(lvl0), .drop_count(dc0));
    cdc_change_queue #(.DATA_WIDTH(8), .DEPTH_BITS(2), .INIT_EVENT(1), .DROP_WIDTH(8)) dut1 (
        .clk(clk), .reset(reset), .data_in(data_in), .q(qif1), .level(lvl1), .drop_count(dc1));
    cdc_change_queue #(.DATA_WIDTH(8), .DEPTH_BITS(2), .INIT_EVENT(0), .DROP_WIDTH(2)) dut2 (
        .clk(clk), .reset(reset), .data_in(data_in), .q(qif2), .level(lvl2), .drop_count(dc2));

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Reference model: each configuration holds its queue as a plain ordered list.
    localparam int QDEPTH = 4;
    int         m_init [3] = '{0, 1, 0};
    int         m_max  [3] = '{255, 255, 3};
    logic [7:0] mq     [3][QDEPTH];
    int         msz    [3];
    logic [7:0] mprev  [3];
    bit         marmed [3];
    int         mdrop  [3];

    task automatic model_update(input logic rst, input logic [7:0] d, input logic r);
        for (int k = 0; k < 3; k++) begin
            if (rst) begin
                msz[k] = 0; marmed[k] = 0; mprev[k] = 8'h00; mdrop[k] = 0;
            end else begin
                bit pop_now;
                bit push_now;
                pop_now  = (msz[k] > 0) && r;
                push_now = marmed[k] ? (d != mprev[k]) : (m_init[k] != 0);
                marmed[k] = 1;
                mprev[k]  = d;
                if (pop_now) begin
                    for (int j = 0; j < QDEPTH - 1; j++) mq[k][j] = mq[k][j+1];
                    msz[k]--;
                end
                if (push_now) begin
                    if (msz[k] < QDEPTH) begin
                        mq[k][msz[k]] = d;
                        msz[k]++;
                    end else if (mdrop[k] < m_max[k]) begin
                        mdrop[k]++;
                    end
                end
            end
        end
    endtask

    task automatic check_all(input string tag);
        int v, l, dc, dt;
        for (int k = 0; k < 3; k++) begin
            case (k)
                0:       begin v = int'(qif0.out_valid); l = int'(lvl0); dc = int'(dc0); dt = int'(qif0.out_data); end
                1:       begin v = int'(qif1.out_valid); l = int'(lvl1); dc = int'(dc1); dt = int'(qif1.out_data); end
                default: begin v = int'(qif2.out_valid); l = int'(lvl2); dc = int'(dc2); dt = int'(qif2.out_data); end
            endcase
            chk($sformatf("%s dut%0d out_valid", tag, k), v, (msz[k] > 0) ? 1 : 0);
            chk($sformatf("%s dut%0d level", tag, k), l, msz[k]);
            chk($sformatf("%s dut%0d drop_count", tag, k), dc, mdrop[k]);
            if (msz[k] > 0) chk($sformatf("%s dut%0d out_data", tag, k), dt, int'(mq[k][0]));
        end
    endtask

    task automatic step(input string tag, input logic rst, input logic [7:0] d, input logic r);
        reset = rst; data_in = d; ready = r;
        @(posedge clk);
        model_update(rst, d, r);
        @(negedge clk);
        $display("[TB] %s rst=%0d d=%02h rdy=%0d -> v=%0d/%0d/%0d lvl=%0d/%0d/%0d drop=%0d/%0d/%0d",
                 tag, rst, d, r, qif0.out_valid, qif1.out_valid, qif2.out_valid,
                 lvl0, lvl1, lvl2, dc0, dc1, dc2);
        check_all(tag);
    endtask

    typedef struct {
        logic       rst;
        logic [7:0] d;
        logic       r;
        logic       v;
        int         lvl;
        int         drop;
        logic [7:0] data;
    } vec_t;

    function automatic vec_t mk(input logic rst, input logic [7:0] d, input logic r,
                                input logic v, input int lvl, input int drop, input logic [7:0] data);
        vec_t t;
        t.rst = rst; t.d = d; t.r = r; t.v = v; t.lvl = lvl; t.drop = drop; t.data = data;
        return t;
    endfunction

    vec_t tbl[$];

    initial begin
        // Expected outputs of the INIT_EVENT=0 configuration after each edge.
        tbl.push_back(mk(1, 8'h00, 0, 0, 0, 0, 8'h00));
        tbl.push_back(mk(0, 8'h5A, 0, 0, 0, 0, 8'h00));
        tbl.push_back(mk(0, 8'h5A, 0, 0, 0, 0, 8'h00));
        tbl.push_back(mk(0, 8'h5A, 0, 0, 0, 0, 8'h00));
        tbl.push_back(mk(0, 8'h11, 1, 1, 1, 0, 8'h11));
        tbl.push_back(mk(0, 8'h22, 1, 1, 1, 0, 8'h22));
        tbl.push_back(mk(0, 8'h22, 1, 0, 0, 0, 8'h00));
        tbl.push_back(mk(0, 8'h01, 0, 1, 1, 0, 8'h01));
        tbl.push_back(mk(0, 8'h02, 0, 1, 2, 0, 8'h01));
        tbl.push_back(mk(0, 8'h03, 0, 1, 3, 0, 8'h01));
        tbl.push_back(mk(0, 8'h04, 0, 1, 4, 0, 8'h01));
        tbl.push_back(mk(0, 8'h05, 0, 1, 4, 1, 8'h01));
        tbl.push_back(mk(0, 8'h06, 0, 1, 4, 2, 8'h01));
        tbl.push_back(mk(0, 8'h07, 1, 1, 4, 2, 8'h02));
        tbl.push_back(mk(0, 8'h07, 1, 1, 3, 2, 8'h03));
        tbl.push_back(mk(0, 8'h07, 1, 1, 2, 2, 8'h04));
        tbl.push_back(mk(0, 8'h07, 1, 1, 1, 2, 8'h07));
        tbl.push_back(mk(0, 8'h07, 1, 0, 0, 2, 8'h00));
        tbl.push_back(mk(0, 8'h08, 0, 1, 1, 2, 8'h08));
        tbl.push_back(mk(0, 8'h09, 0, 1, 2, 2, 8'h08));
        tbl.push_back(mk(0, 8'h0A, 0, 1, 3, 2, 8'h08));
        tbl.push_back(mk(1, 8'h0A, 0, 0, 0, 0, 8'h00));
        tbl.push_back(mk(0, 8'h0B, 0, 0, 0, 0, 8'h00));
        tbl.push_back(mk(0, 8'h0B, 0, 0, 0, 0, 8'h00));
        tbl.push_back(mk(0, 8'h0C, 0, 1, 1, 0, 8'h0C));

        for (int i = 0; i < tbl.size(); i++) begin
            step($sformatf("vec%0d", i), tbl[i].rst, tbl[i].d, tbl[i].r);
            chk($sformatf("vec%0d out_valid", i), int'(qif0.out_valid), int'(tbl[i].v));
            chk($sformatf("vec%0d level", i), int'(lvl0), tbl[i].lvl);
            chk($sformatf("vec%0d drop_count", i), int'(dc0), tbl[i].drop);
            if (tbl[i].v) chk($sformatf("vec%0d out_data", i), int'(qif0.out_data), int'(tbl[i].data));
            if (i == 1) begin
                chk("init_event out_valid", int'(qif1.out_valid), 1);
                chk("init_event out_data", int'(qif1.out_data), 'h5A);
            end
        end

        // Ten distinct changes on a stalled consumer: narrow drop counter must saturate.
        step("sat", 1'b1, 8'h80, 1'b0);
        step("sat", 1'b0, 8'h80, 1'b0);
        for (int j = 1; j <= 10; j++) step("sat", 1'b0, 8'h80 + 8'(j), 1'b0);
        chk("sat dut0 drop_count", int'(dc0), 6);
        chk("sat dut1 drop_count", int'(dc1), 7);
        chk("sat dut2 drop_count", int'(dc2), 3);
        chk("sat dut2 level", int'(lvl2), 4);
        chk("sat dut2 head", int'(qif2.out_data), 'h81);

        // Random traffic with narrow value range so repeats and drops are common.
        step("rnd", 1'b1, 8'h00, 1'b0);
        for (int n = 0; n < 500; n++) begin
            step("rnd", ($urandom_range(0, 59) == 0), 8'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/cdc_change_queue.md
Name: cdc_change_queue

Overview:
- Downstream consumer of the multi-bit CDC synchronizer output, in the destination clock domain.
- Watches the synchronized value and detects every change.
- Each new value is queued in a small FIFO and presented on a valid/ready interface, so slow consumers never miss a transition.
- Counts changes lost to FIFO overflow.

Parameters:
DATA_WIDTH, 8, width of monitored value and queued entries
DEPTH_BITS, 2, log2 of FIFO depth (depth = 2**DEPTH_BITS, minimum 1)
INIT_EVENT, 0, 1 = first sample after reset is queued as an event; 0 = first sample only sets the baseline
DROP_WIDTH, 8, width of saturating drop counter

Ports:
clk  in  1  destination-domain clock
reset  in  1  synchronous reset, active-high
data_in  in  DATA_WIDTH  synchronized value (from synchronizer data_out)
out_data  out  DATA_WIDTH  head-of-queue value (valid only when out_valid=1)
out_valid  out  1  queue not empty
out_ready  in  1  consumer accepts head this cycle
level  out  DEPTH_BITS+1  current number of queued entries
drop_count  out  DROP_WIDTH  changes discarded because queue was full, saturating

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high, named reset.
- Reset values: out_valid=0, level=0, drop_count=0, internal prev=0, armed=0, read/write pointers=0. out_data is don't-care while out_valid=0. A reset mid-operation discards all queued entries.
- Baseline: the first clk edge with reset=0 loads prev<=data_in and sets armed=1.
  - If INIT_EVENT=1, that sample is also pushed.
  - If INIT_EVENT=0, nothing is pushed.
- Change detect: at each edge with armed=1, change = (data_in != prev); prev<=data_in every cycle.
- Push: push request = change (or the initial event).
  - The entry is written at the same edge.
  - out_valid/level reflect it immediately after that edge, so a change visible before edge k gives out_valid=1 after edge k (1-cycle latency).
- FIFO is show-ahead: out_data = mem[rd_ptr] combinationally from the registered pointer/memory; there is no extra read latency.
- Pop: pop = out_valid & out_ready. rd_ptr advances and level decrements at the edge.
- Simultaneous push and pop:
  - Non-empty: both happen; level unchanged.
  - Empty: only the push is accepted, because pop requires out_valid.
  - Full: the pop frees a slot and the push is accepted (no drop).
- Full without pop: the push is discarded, queue contents are unchanged, drop_count increments. drop_count saturates at 2**DROP_WIDTH-1 and is cleared only by reset.
- Pointers: DEPTH_BITS wide, wrap modulo depth. Full is level==depth; empty is level==0.
- out_ready while out_valid=0: ignored.
- Ordering: entries are delivered strictly in change order. Consecutive identical values are never queued twice.

Decomposition:
- No shared package needed.
- Local constant DEPTH = 1<<DEPTH_BITS.
- One natural sub-module: showahead_fifo (parameters DATA_WIDTH, DEPTH_BITS; ports clk, reset, push, push_data, pop, head_data, level, full, empty).
- The top holds baseline/change detection and the drop counter.

Test Plan:
- INIT_EVENT=0, reset then data_in=0x5A held 10 cycles -> out_valid stays 0, level=0, drop_count=0. Repeat with INIT_EVENT=1 -> one entry 0x5A, out_valid=1 one cycle after first armed edge.
- out_ready=1, data_in 0x00->0x11->0x22 on successive cycles -> out_data 0x11 then 0x22, each out_valid one cycle after its change, level never above 1.
- out_ready=0, DEPTH_BITS=2, six distinct changes 0x01..0x06 -> level=4 holding 0x01..0x04, drop_count=2. Then out_ready=1 -> pops 0x01,0x02,0x03,0x04, then out_valid=0.
- Queue full (level=4), change arrives in the same cycle as out_ready=1 -> level stays 4, drop_count unchanged, new value delivered last.
- DROP_WIDTH=2, out_ready=0, full queue, 6 further changes -> drop_count saturates at 3.
- Reset asserted with level=3 -> next cycle out_valid=0, level=0, drop_count=0. The first post-reset sample re-baselines with no event when INIT_EVENT=0.
